// File: rtl/fetch_irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_irq_ctrl_pkg
//  Brief    : Shared types and default constants for the fetch/IRQ controller
//  Revision : 1.0
// ============================================================================
package fetch_irq_ctrl_pkg;

  typedef enum logic [1:0] {
    REDIR_NONE   = 2'd0,
    REDIR_BRANCH = 2'd1,
    REDIR_RTI    = 2'd2,
    REDIR_IRQ    = 2'd3
  } redir_e;

  localparam int          c_XLEN_DEFAULT     = 32;
  localparam logic [31:0] c_RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] c_VEC_BASE_DEFAULT = 32'h0000_0100;

endpackage
`default_nettype wire

// File: rtl/fetch_irq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_irq_ctrl_if
//  Brief    : Fetch-stage bundle: redirect inputs, IRQ lines, imem and decode
//  Revision : 1.0
// ============================================================================
interface fetch_irq_ctrl_if #(
  parameter int XLEN        = 32,
  parameter int NUM_IRQ     = 4,
  parameter int STACK_DEPTH = 4
);

  logic                               stall;
  logic                               branch;
  logic [XLEN-1:0]                    pc_ex;
  logic                               rti;
  logic [NUM_IRQ-1:0]                 irq;
  logic [NUM_IRQ-1:0]                 irq_en;
  logic [XLEN-1:0]                    imem_addr;
  logic [XLEN-1:0]                    imem_rdata;
  logic [XLEN-1:0]                    pc_dec;
  logic [XLEN-1:0]                    instruction_dec;
  logic                               dec_valid;
  logic                               irq_ack;
  logic [$clog2(NUM_IRQ)-1:0]         irq_ack_id;
  logic [$clog2(STACK_DEPTH+1)-1:0]   isr_depth;
  logic                               rti_err;

  modport master (
    input  stall, branch, pc_ex, rti, irq, irq_en, imem_rdata,
    output imem_addr, pc_dec, instruction_dec, dec_valid,
           irq_ack, irq_ack_id, isr_depth, rti_err
  );

  modport slave (
    output stall, branch, pc_ex, rti, irq, irq_en, imem_rdata,
    input  imem_addr, pc_dec, instruction_dec, dec_valid,
           irq_ack, irq_ack_id, isr_depth, rti_err
  );

endinterface
`default_nettype wire

// File: rtl/irq_return_stack.sv
`default_nettype none
// ============================================================================
//  Module   : irq_return_stack
//  Brief    : LIFO of interrupt return frames; top entry is read combinationally
//  Revision : 1.0
// ============================================================================
module irq_return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic                         i_push,
  input  wire logic                         i_pop,
  input  wire logic [W-1:0]                 i_push_data,
  output logic      [W-1:0]                 o_pop_data,
  output logic                              o_full,
  output logic                              o_empty,
  output logic      [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int c_CNT_W = $clog2(DEPTH+1);
  localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]       r_mem [DEPTH];
  logic [c_CNT_W-1:0] r_count;
  logic [c_PTR_W-1:0] w_top_idx;
  logic [c_PTR_W-1:0] w_push_idx;

  assign o_full     = (r_count == c_CNT_W'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign w_push_idx = c_PTR_W'(r_count);
  // Guard keeps the read index in range while the stack is empty.
  assign w_top_idx  = o_empty ? '0 : c_PTR_W'(r_count - c_CNT_W'(1));
  assign o_pop_data = r_mem[w_top_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_push && !o_full) begin
      r_count <= r_count + c_CNT_W'(1);
    end else if (i_pop && !o_empty) begin
      r_count <= r_count - c_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !o_full) begin
      r_mem[w_push_idx] <= i_push_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_irq_ctrl
//  Brief    : Fetch stage with branch redirect, prioritised nested vectored IRQs
//  Revision : 1.0
// ============================================================================
module fetch_irq_ctrl
  import fetch_irq_ctrl_pkg::*;
#(
  parameter int              XLEN        = c_XLEN_DEFAULT,
  parameter int              NUM_IRQ     = 4,
  parameter int              STACK_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(c_RESET_PC_DEFAULT),
  parameter int unsigned     PC_INC      = 1,
  parameter logic [XLEN-1:0] VEC_BASE    = XLEN'(c_VEC_BASE_DEFAULT),
  parameter int unsigned     VEC_STRIDE  = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  fetch_irq_ctrl_if.master   bus
);

  localparam int c_ID_W    = $clog2(NUM_IRQ);
  localparam int c_LVL_W   = $clog2(NUM_IRQ+1);
  localparam int c_DEPTH_W = $clog2(STACK_DEPTH+1);
  // Level NUM_IRQ means "not in any ISR": every channel index is below it.
  localparam logic [c_LVL_W-1:0] c_NO_ISR = c_LVL_W'(NUM_IRQ);

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [c_LVL_W-1:0] level;
  } stack_entry_t;

  logic [XLEN-1:0]      r_pc;
  logic [XLEN-1:0]      r_pc_dec;
  logic [XLEN-1:0]      r_instr_dec;
  logic                 r_dec_valid;
  logic                 r_started;
  logic [NUM_IRQ-1:0]   r_irq_prev;
  logic [NUM_IRQ-1:0]   r_pending;
  logic [c_LVL_W-1:0]   r_cur_level;
  logic                 r_irq_ack;
  logic [c_ID_W-1:0]    r_irq_ack_id;
  logic                 r_rti_err;

  logic [NUM_IRQ-1:0]   w_rise;
  logic [NUM_IRQ-1:0]   w_ack_mask;
  logic                 w_win_found;
  logic [c_ID_W-1:0]    w_win_id;
  redir_e               w_cause;
  logic                 w_rti_err;
  logic                 w_push;
  logic                 w_pop;
  logic [XLEN-1:0]      w_vector;
  logic [XLEN-1:0]      w_pc_next;
  stack_entry_t         w_push_entry;
  stack_entry_t         w_pop_entry;
  logic                 w_full;
  logic                 w_empty;
  logic [c_DEPTH_W-1:0] w_count;

  assign w_rise = bus.irq & ~r_irq_prev;

  // Descending scan so the lowest eligible index is the last one written.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (r_pending[i] && bus.irq_en[i] && (c_LVL_W'(i) < r_cur_level)) begin
        w_win_found = 1'b1;
        w_win_id    = c_ID_W'(i);
      end
    end
  end

  always_comb begin
    w_cause   = REDIR_NONE;
    w_rti_err = 1'b0;
    if (!bus.stall) begin
      if (bus.branch) begin
        w_cause = REDIR_BRANCH;
      end else if (bus.rti) begin
        if (!w_empty) begin
          w_cause = REDIR_RTI;
        end else begin
          w_rti_err = 1'b1;
        end
      end else if (w_win_found && !w_full) begin
        w_cause = REDIR_IRQ;
      end
    end
  end

  assign w_push   = (w_cause == REDIR_IRQ);
  assign w_pop    = (w_cause == REDIR_RTI);
  assign w_vector = VEC_BASE + (XLEN'(w_win_id) * XLEN'(VEC_STRIDE));

  always_comb begin
    w_pc_next = r_pc + XLEN'(PC_INC);
    case (w_cause)
      REDIR_BRANCH: w_pc_next = bus.pc_ex;
      REDIR_RTI:    w_pc_next = w_pop_entry.pc;
      REDIR_IRQ:    w_pc_next = w_vector;
      default:      w_pc_next = r_pc + XLEN'(PC_INC);
    endcase
  end

  always_comb begin
    w_ack_mask = '0;
    if (w_push) begin
      w_ack_mask[w_win_id] = 1'b1;
    end
  end

  // The saved PC is the one not yet fetched, so the return re-fetches it.
  assign w_push_entry = '{pc: r_pc, level: r_cur_level};

  irq_return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     ($bits(stack_entry_t))
  ) u_stack (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_push_data (w_push_entry),
    .o_pop_data  (w_pop_entry),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_pc_dec     <= '0;
      r_instr_dec  <= '0;
      r_dec_valid  <= 1'b0;
      r_started    <= 1'b0;
      r_irq_prev   <= '0;
      r_pending    <= '0;
      r_cur_level  <= c_NO_ISR;
      r_irq_ack    <= 1'b0;
      r_irq_ack_id <= '0;
      r_rti_err    <= 1'b0;
    end else begin
      // Edge capture runs every cycle, stalled or not.
      r_irq_prev <= bus.irq;
      r_pending  <= (r_pending & ~w_ack_mask) | w_rise;
      r_irq_ack  <= w_push;
      r_rti_err  <= w_rti_err;
      if (w_push) begin
        r_irq_ack_id <= w_win_id;
      end
      if (!bus.stall) begin
        r_pc        <= w_pc_next;
        r_pc_dec    <= r_pc;
        r_instr_dec <= bus.imem_rdata;
        r_dec_valid <= r_started && (w_cause == REDIR_NONE);
        r_started   <= 1'b1;
        if (w_push) begin
          r_cur_level <= c_LVL_W'(w_win_id);
        end else if (w_pop) begin
          r_cur_level <= w_pop_entry.level;
        end
      end
    end
  end

  assign bus.imem_addr       = r_pc;
  assign bus.pc_dec          = r_pc_dec;
  assign bus.instruction_dec = r_instr_dec;
  assign bus.dec_valid       = r_dec_valid;
  assign bus.irq_ack         = r_irq_ack;
  assign bus.irq_ack_id      = r_irq_ack_id;
  assign bus.isr_depth       = w_count;
  assign bus.rti_err         = r_rti_err;

endmodule
`default_nettype wire

// File: tb/tb_fetch_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_irq_ctrl
//  Brief    : Directed self-checking bench for fetch_irq_ctrl (depth 4 and 1)
//  Revision : 1.0
// ============================================================================
module tb_fetch_irq_ctrl;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_b = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fetch_irq_ctrl_if #(.XLEN(32), .NUM_IRQ(4), .STACK_DEPTH(4)) bus_a ();
  fetch_irq_ctrl_if #(.XLEN(32), .NUM_IRQ(4), .STACK_DEPTH(1)) bus_b ();

  fetch_irq_ctrl #(.XLEN(32), .NUM_IRQ(4), .STACK_DEPTH(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  fetch_irq_ctrl #(.XLEN(32), .NUM_IRQ(4), .STACK_DEPTH(1)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_a(input string tag, input logic [31:0] addr, input int depth,
                       input int ack, input int dv);
    check_eq({tag, ".addr"},  bus_a.imem_addr, addr);
    check_eq({tag, ".depth"}, 32'(bus_a.isr_depth), 32'(depth));
    check_eq({tag, ".ack"},   32'(bus_a.irq_ack), 32'(ack));
    check_eq({tag, ".dv"},    32'(bus_a.dec_valid), 32'(dv));
  endtask

  task automatic exp_b(input string tag, input logic [31:0] addr, input int depth, input int ack);
    check_eq({tag, ".addr"},  bus_b.imem_addr, addr);
    check_eq({tag, ".depth"}, 32'(bus_b.isr_depth), 32'(depth));
    check_eq({tag, ".ack"},   32'(bus_b.irq_ack), 32'(ack));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_a.stall = 0; bus_a.branch = 0; bus_a.pc_ex = 0; bus_a.rti = 0;
    bus_a.irq = 0; bus_a.irq_en = 4'hF; bus_a.imem_rdata = 32'h1234_5678;
    bus_b.stall = 0; bus_b.branch = 0; bus_b.pc_ex = 0; bus_b.rti = 0;
    bus_b.irq = 0; bus_b.irq_en = 4'hF; bus_b.imem_rdata = 32'h0;

    // Reset state
    tick(); tick();
    exp_a("rst", 32'h0, 0, 0, 0);
    check_eq("rst.pc_dec", bus_a.pc_dec, 32'h0);
    check_eq("rst.rti_err", 32'(bus_a.rti_err), 0);
    check_eq("rst.ack_id", 32'(bus_a.irq_ack_id), 0);

    // Sequential fetch
    rst = 0;
    tick();
    exp_a("seq1", 32'd1, 0, 0, 0);
    check_eq("seq1.pc_dec", bus_a.pc_dec, 32'd0);
    bus_a.imem_rdata = 32'hC0DE_0001;
    tick();
    exp_a("seq2", 32'd2, 0, 0, 1);
    check_eq("seq2.pc_dec", bus_a.pc_dec, 32'd1);
    check_eq("seq2.instr", bus_a.instruction_dec, 32'hC0DE_0001);
    bus_a.imem_rdata = 32'h1234_5678;
    repeat (8) tick();
    exp_a("seq10", 32'd10, 0, 0, 1);

    // Branch to 6 at pc 10
    bus_a.branch = 1; bus_a.pc_ex = 32'd6;
    tick();
    exp_a("br", 32'd6, 0, 0, 0);
    check_eq("br.pc_dec", bus_a.pc_dec, 32'd10);
    bus_a.branch = 0;
    tick(); exp_a("br+1", 32'd7, 0, 0, 1);
    tick(); exp_a("br+2", 32'd8, 0, 0, 1);

    // irq[2] taken at pc 5
    bus_a.branch = 1; bus_a.pc_ex = 32'd4;
    tick(); exp_a("br4", 32'd4, 0, 0, 0);
    bus_a.branch = 0; bus_a.irq = 4'b0100;
    tick(); exp_a("irq2.cap", 32'd5, 0, 0, 1);
    bus_a.irq = 0;
    tick(); exp_a("irq2.take", 32'h108, 1, 1, 0);
    check_eq("irq2.id", 32'(bus_a.irq_ack_id), 2);
    check_eq("irq2.pc_dec", bus_a.pc_dec, 32'd5);
    tick(); exp_a("irq2+1", 32'h109, 1, 0, 1);

    // Lower-priority ch3 stays pending, higher-priority ch0 nests
    bus_a.irq = 4'b1000;
    tick(); exp_a("irq3.cap", 32'h10A, 1, 0, 1);
    bus_a.irq = 0;
    tick(); exp_a("irq3.held", 32'h10B, 1, 0, 1);
    bus_a.irq = 4'b0001;
    tick(); exp_a("irq0.cap", 32'h10C, 1, 0, 1);
    bus_a.irq = 0;
    tick(); exp_a("irq0.take", 32'h100, 2, 1, 0);
    check_eq("irq0.id", 32'(bus_a.irq_ack_id), 0);
    tick(); exp_a("irq0+1", 32'h101, 2, 0, 1);

    // Unwind both levels, then ch3 fires
    bus_a.rti = 1;
    tick(); exp_a("rti1", 32'h10C, 1, 0, 0);
    tick(); exp_a("rti2", 32'd5, 0, 0, 0);
    bus_a.rti = 0;
    tick(); exp_a("irq3.take", 32'h10C, 1, 1, 0);
    check_eq("irq3.id", 32'(bus_a.irq_ack_id), 3);
    tick(); exp_a("irq3+1", 32'h10D, 1, 0, 1);
    bus_a.rti = 1;
    tick(); exp_a("rti3", 32'd5, 0, 0, 0);

    // rti with empty stack
    tick(); exp_a("rtierr", 32'd6, 0, 0, 1);
    check_eq("rtierr.pulse", 32'(bus_a.rti_err), 1);
    bus_a.rti = 0;
    tick(); exp_a("rtierr+1", 32'd7, 0, 0, 1);
    check_eq("rtierr+1.pulse", 32'(bus_a.rti_err), 0);

    // branch and rti together: branch wins, no pop
    bus_a.irq = 4'b0010;
    tick(); exp_a("irq1.cap", 32'd8, 0, 0, 1);
    bus_a.irq = 0;
    tick(); exp_a("irq1.take", 32'h104, 1, 1, 0);
    bus_a.branch = 1; bus_a.pc_ex = 32'h40; bus_a.rti = 1;
    tick(); exp_a("br+rti", 32'h40, 1, 0, 0);
    check_eq("br+rti.err", 32'(bus_a.rti_err), 0);
    bus_a.branch = 0;
    tick(); exp_a("rti4", 32'd8, 0, 0, 0);
    bus_a.rti = 0;

    // Stall with branch and irq edge held throughout
    bus_a.stall = 1; bus_a.branch = 1; bus_a.pc_ex = 32'h20;
    bus_a.irq = 4'b0100; bus_a.imem_rdata = 32'hFFFF_0000;
    for (int k = 0; k < 3; k++) begin
      tick(); exp_a("stall", 32'd8, 0, 0, 0);
    end
    check_eq("stall.pc_dec", bus_a.pc_dec, 32'h40);
    check_eq("stall.instr", bus_a.instruction_dec, 32'h1234_5678);
    bus_a.stall = 0;
    tick(); exp_a("unstall.br", 32'h20, 0, 0, 0);
    bus_a.branch = 0;
    tick(); exp_a("unstall.irq", 32'h108, 1, 1, 0);
    check_eq("unstall.id", 32'(bus_a.irq_ack_id), 2);
    bus_a.irq = 0; bus_a.rti = 1;
    tick(); exp_a("unstall.rti", 32'h20, 0, 0, 0);
    bus_a.rti = 0;

    // Single-entry stack: nested edge held until rti frees the slot
    rst_b = 0;
    tick(); exp_b("b.seq1", 32'd1, 0, 0);
    bus_b.irq = 4'b0100;
    tick(); exp_b("b.cap2", 32'd2, 0, 0);
    bus_b.irq = 0;
    tick(); exp_b("b.take2", 32'h108, 1, 1);
    tick(); exp_b("b.take2+1", 32'h109, 1, 0);
    bus_b.irq = 4'b0001;
    tick(); exp_b("b.cap0", 32'h10A, 1, 0);
    bus_b.irq = 0;
    tick(); exp_b("b.full", 32'h10B, 1, 0);
    bus_b.rti = 1;
    tick(); exp_b("b.rti", 32'd2, 0, 0);
    bus_b.rti = 0;
    tick(); exp_b("b.take0", 32'h100, 1, 1);
    check_eq("b.take0.id", 32'(bus_b.irq_ack_id), 0);

    // Asynchronous reset mid-ISR discards stack and pending
    rst_b = 1;
    #1;
    exp_b("b.arst", 32'h0, 0, 0);
    tick();
    rst_b = 0;
    tick(); exp_b("b.post1", 32'd1, 0, 0);
    tick(); exp_b("b.post2", 32'd2, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_irq_ctrl.md
Name: fetch_irq_ctrl

Overview:
Parametrised next-generation fetch stage: PC generation, branch redirect, N-channel prioritised vectored interrupts and a nested return-PC stack.
Drives synchronous instruction-memory address; registers PC and instruction into decode.
Replaces fixed two-source (key/eth) interrupt handling with NUM_IRQ channels, per-channel enable, nesting and stall support.

Parameters:
XLEN, 32, PC/instruction width
NUM_IRQ, 4, interrupt channels; index 0 = highest priority
STACK_DEPTH, 4, max nested interrupt levels saved
RESET_PC, 0, PC after reset
PC_INC, 1, sequential PC increment
VEC_BASE, 32'h100, vector for channel 0
VEC_STRIDE, 4, vector spacing; vector(i) = VEC_BASE + i*VEC_STRIDE

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset; asynchronous, active-high
stall  in  1  hold PC and decode registers
branch  in  1  execute-stage taken branch/jump
pc_ex  in  XLEN  branch target
rti  in  1  return-from-interrupt, execute stage
irq  in  NUM_IRQ  interrupt request lines, level, synchronous to clk
irq_en  in  NUM_IRQ  per-channel enable
imem_addr  out  XLEN  = pc (combinational from PC register)
imem_rdata  in  XLEN  instruction, valid one cycle after imem_addr
pc_dec  out  XLEN  PC of instruction in decode
instruction_dec  out  XLEN  instruction in decode
dec_valid  out  1  decode slot holds a real instruction
irq_ack  out  1  one-cycle pulse, interrupt taken
irq_ack_id  out  $clog2(NUM_IRQ)  channel taken
isr_depth  out  $clog2(STACK_DEPTH+1)  current nesting depth
rti_err  out  1  one-cycle pulse, rti with empty stack

Behaviour:
- Reset (async, immediate): pc=RESET_PC; pc_dec=0; dec_valid=0; pending=0; stack empty; cur_level=NUM_IRQ (no ISR); irq_ack=0; irq_ack_id=0; rti_err=0. Reset mid-ISR discards stack and pending.
- Pending capture: pending[i] set on rising edge of irq[i] (registered prev sample); cleared when channel i acknowledged. Captured even while stalled or masked.
- Eligible: pending[i] & irq_en[i] & (i < cur_level). Winner = lowest eligible index.
- Redirect priority per non-stalled cycle:
  - branch: pc<=pc_ex; rti ignored that cycle (no pop, no err); interrupts wait.
  - else rti:
    - stack non-empty: pop {pc_saved, level_saved}; pc<=pc_saved; cur_level<=level_saved.
    - stack empty: pc<=pc+PC_INC; rti_err=1.
  - else winner exists and depth<STACK_DEPTH: push {pc, cur_level}; pc<=vector(winner); cur_level<=winner; irq_ack=1, irq_ack_id=winner; pending[winner] cleared.
  - else: pc<=pc+PC_INC (XLEN wrap-around, no saturation).
- Full stack: interrupts remain pending, taken after rti frees a slot.
- Decode register, non-stalled cycle: pc_dec<=pc; instruction_dec<=imem_rdata.
  - dec_valid<=0 in the cycle after reset release and on any redirect (branch, rti pop, irq); else 1.
  - rti_err cycle is not a redirect.
- Stall: pc, pc_dec, instruction_dec, dec_valid, stack, cur_level held; redirect inputs ignored (execute holds them until unstalled); irq_ack/rti_err stay 0.
- Latency: interrupt edge to vector on imem_addr = 2 cycles (capture, then redirect) absent stall/branch/rti.
- Interrupted PC saved is the unfetched pc, so return re-fetches it; no instruction lost or duplicated.
- isr_depth = stack occupancy.

Decomposition:
- fetch_pkg:
  - redirect-cause enum (REDIR_NONE, REDIR_BRANCH, REDIR_RTI, REDIR_IRQ)
  - stack-entry struct {pc, level}
  - default RESET_PC/VEC_BASE constants
- Sub-module irq_return_stack: LIFO of STACK_DEPTH entries; push/pop/full/empty/count; simultaneous push+pop not required (priority excludes it).

Test Plan:
- Reset release, no events, PC_INC=1: imem_addr 0,1,2,...; dec_valid 0 first cycle then 1; pc_dec trails imem_addr by one.
- Branch pc_ex=6 at pc=10: next imem_addr=6, dec_valid=0 one cycle, then 7,8.
- irq[2] rising edge, enabled, at pc=5: irq_ack=1/id=2 in the redirect cycle, imem_addr=0x108, isr_depth=1. Later rti: imem_addr=5 (redirect PC 5 fetched, not 6), isr_depth=0.
- Nesting:
  - In ISR for channel 2, irq[3] edge: stays pending; irq[0] edge: taken, isr_depth=2.
  - rti, rti: back through ch2 ISR to original PC.
  - Channel 3 then taken once cur_level returns to NUM_IRQ.
- STACK_DEPTH=1 build, nested higher-priority edge held pending until rti. Separately: rti at depth 0 gives rti_err pulse, PC sequential. branch+rti same cycle: branch target taken, no pop.
- Stall 3 cycles with irq edge and branch asserted throughout: all outputs frozen, irq_ack=0; after release branch taken first, irq acked next non-stalled cycle.
